icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream requester) and the memory controller's fetch port (downstream).
- A hit returns the 32-bit instruction one cycle after the request is accepted.
- A miss fills a 4-word line with four sequential word reads over the memory-controller fetch handshake, then returns the instruction.
- Flush on rollback / PC redirect drops the pending response but never corrupts the array.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_array.sv | 49 ++++
 rtl/icache.sv | 157 +++++++++++++++
 tb/tb_icache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state type for the direct-mapped instruction cache.
package icache_pkg;

   localparam int ICACHE_ADDR_WID   = 32;
   localparam int ICACHE_DATA_WID   = 32;
   localparam int ICACHE_IDX_WID    = 6;
   localparam int ICACHE_TAG_WID    = ICACHE_ADDR_WID - 4 - ICACHE_IDX_WID;
   localparam int ICACHE_LINE_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RESP = 2'd2
   } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read by index, synchronous whole-line
// write, valid bits cleared asynchronously on rst.
module icache_array
   import icache_pkg::*;
#(
   parameter int IDX_WID  = ICACHE_IDX_WID,
   parameter int TAG_WID  = ICACHE_TAG_WID,
   parameter int WORD_WID = ICACHE_DATA_WID
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [IDX_WID-1:0]                           rd_idx,
   output logic                                         rd_valid,
   output logic [TAG_WID-1:0]                           rd_tag,
   output logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0]   rd_line,
   input  logic                                         wr_en,
   input  logic [IDX_WID-1:0]                           wr_idx,
   input  logic [TAG_WID-1:0]                           wr_tag,
   input  logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0]   wr_line
);

   localparam int LINES = 2 ** IDX_WID;

   logic [LINES-1:0]                           valid;
   logic [TAG_WID-1:0]                         tag_mem  [LINES];
   logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0] data_mem [LINES];

   // Valid bits: async clear, set when a line is installed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data storage: written only on line install, no reset needed
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-word lines.
// Hits answer one cycle after acceptance; misses fill the line with four
// sequential word reads, install it, then answer from the line buffer.
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache
   import icache_pkg::*;
#(
   parameter int IDX_WID  = ICACHE_IDX_WID,
   parameter int ADDR_WID = ICACHE_ADDR_WID,
   parameter int WORD_WID = ICACHE_DATA_WID
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                flush,
   input  logic                if_req,
   input  logic [ADDR_WID-1:0] if_pc,
   output logic                if_done,
   output logic [WORD_WID-1:0] if_inst,
   output logic                mc_en,
   output logic [ADDR_WID-1:0] mc_pc,
   input  logic                mc_done,
   input  logic [WORD_WID-1:0] mc_data
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0]         stat_hit,
   output logic [31:0]         stat_miss
`endif
);

   localparam int TAG_WID = ADDR_WID - 4 - IDX_WID;

   icache_state_t                               state;
   logic [ADDR_WID-1:0]                         req_pc;
   logic [1:0]                                  cnt;
   logic                                        kill;
   logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0]  line_buf;

   logic                                        rd_valid;
   logic [TAG_WID-1:0]                          rd_tag;
   logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0]  rd_line;
   logic                                        hit;
   logic                                        accept;
   logic                                        wr_en;
   logic [ICACHE_LINE_WORDS-1:0][WORD_WID-1:0]  wr_line;
   logic                                        unused_pc_bits;

   // A registered if_done blocks acceptance so the still-held request that
   // produced it cannot be answered twice.
   assign accept = (state == IDLE) && if_req && !flush && !if_done;
   assign hit    = rd_valid && (rd_tag == if_pc[ADDR_WID-1:4+IDX_WID]);

   // Last word goes straight from mc_data into the array together with the
   // three already buffered words.
   assign wr_en   = rdy && (state == FILL) && mc_en && mc_done && (cnt == 2'd3);
   assign wr_line = {mc_data, line_buf[2], line_buf[1], line_buf[0]};

   assign unused_pc_bits = ^{if_pc[1:0], req_pc[1:0]};

   icache_array #(
      .IDX_WID  (IDX_WID),
      .TAG_WID  (TAG_WID),
      .WORD_WID (WORD_WID)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (if_pc[4+IDX_WID-1:4]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_idx   (req_pc[4+IDX_WID-1:4]),
      .wr_tag   (req_pc[ADDR_WID-1:4+IDX_WID]),
      .wr_line  (wr_line)
   );

   // Control FSM with registered fetcher and memory-controller outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req_pc   <= '0;
         cnt      <= '0;
         kill     <= 1'b0;
         line_buf <= '0;
         if_done  <= 1'b0;
         if_inst  <= '0;
         mc_en    <= 1'b0;
         mc_pc    <= '0;
      end else if (rdy) begin
         if_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_pc <= if_pc;
                  if (hit) begin
                     if_done <= 1'b1;
                     if_inst <= rd_line[if_pc[3:2]];
                  end else begin
                     state <= FILL;
                     cnt   <= '0;
                     kill  <= 1'b0;
                     mc_en <= 1'b1;
                     mc_pc <= {if_pc[ADDR_WID-1:4], 4'b0000};
                  end
               end
            end
            FILL: begin
               if (flush) begin
                  kill <= 1'b1;
               end
               if (!mc_en) begin
                  mc_en <= 1'b1;
               end else if (mc_done) begin
                  line_buf[cnt] <= mc_data;
                  mc_en         <= 1'b0;
                  if (cnt == 2'd3) begin
                     // A flush seen on this very cycle counts as a kill too.
                     state <= (kill || flush) ? IDLE : RESP;
                     kill  <= 1'b0;
                     cnt   <= '0;
                  end else begin
                     cnt   <= cnt + 2'd1;
                     mc_pc <= mc_pc + ADDR_WID'(4);
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               if (!flush) begin
                  if_done <= 1'b1;
                  if_inst <= line_buf[req_pc[3:2]];
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ICACHE_STAT_EN
   // Hit/miss counters, stepped once per accepted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hit  <= '0;
         stat_miss <= '0;
      end else if (rdy && accept) begin
         if (hit) begin
            stat_hit <= stat_hit + 32'd1;
         end else begin
            stat_miss <= stat_miss + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mc_en;
   logic [31:0] mc_pc;
   logic        mc_done;
   logic [31:0] mc_data;
`ifdef ICACHE_STAT_EN
   logic [31:0] stat_hit;
   logic [31:0] stat_miss;
`endif

   int checks   = 0;
   int failures = 0;

   icache dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .if_req    (if_req),
      .if_pc     (if_pc),
      .if_done   (if_done),
      .if_inst   (if_inst),
      .mc_en     (mc_en),
      .mc_pc     (mc_pc),
      .mc_done   (mc_done),
      .mc_data   (mc_data)
`ifdef ICACHE_STAT_EN
      ,
      .stat_hit  (stat_hit),
      .stat_miss (stat_miss)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Serve four word reads; optionally flush after word flush_after and
   // stall with rdy low for 5 cycles before answering word stall_at.
   task automatic serve_fill(input logic [31:0] base, input logic [3:0][31:0] w,
                             input int flush_after, input int stall_at);
      for (int i = 0; i < 4; i++) begin
         int n;
         n = 0;
         while (mc_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("fill_req_seen", 32'(mc_en), 32'd1);
         check("fill_addr", mc_pc, base + 32'(4 * i));
         if (i == stall_at) begin
            rdy = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check("stall_mc_en", 32'(mc_en), 32'd1);
               check("stall_mc_pc", mc_pc, base + 32'(4 * i));
            end
            rdy = 1'b1;
         end
         mc_done = 1'b1;
         mc_data = w[i];
         @(negedge clk);
         mc_done = 1'b0;
         check("fill_gap", 32'(mc_en), 32'd0);
         check("fill_no_done", 32'(if_done), 32'd0);
         if (i == flush_after) begin
            flush  = 1'b1;
            if_req = 1'b0;
            @(negedge clk);
            flush  = 1'b0;
         end
      end
   endtask

   // Request expected to hit; request is held one extra cycle to confirm
   // the response is a single pulse.
   task automatic hit_req(input logic [31:0] pc, input logic [31:0] exp);
      if_req = 1'b1;
      if_pc  = pc;
      @(negedge clk);
      check("hit_done", 32'(if_done), 32'd1);
      check("hit_inst", if_inst, exp);
      check("hit_no_mc", 32'(mc_en), 32'd0);
      @(negedge clk);
      check("hit_pulse_end", 32'(if_done), 32'd0);
      check("hit_no_mc2", 32'(mc_en), 32'd0);
      if_req = 1'b0;
   endtask

   // Request expected to miss and be filled from base with words w.
   task automatic miss_req(input logic [31:0] pc, input logic [31:0] base,
                           input logic [3:0][31:0] w, input int stall_at);
      if_req = 1'b1;
      if_pc  = pc;
      @(negedge clk);
      check("miss_no_done", 32'(if_done), 32'd0);
      serve_fill(base, w, -1, stall_at);
      @(negedge clk);
      check("miss_resp_done", 32'(if_done), 32'd1);
      check("miss_resp_inst", if_inst, w[pc[3:2]]);
      check("miss_resp_no_mc", 32'(mc_en), 32'd0);
      @(negedge clk);
      check("miss_pulse_end", 32'(if_done), 32'd0);
      if_req = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      rdy     = 1'b1;
      flush   = 1'b0;
      if_req  = 1'b0;
      if_pc   = '0;
      mc_done = 1'b0;
      mc_data = '0;

      // Reset state
      @(negedge clk);
      check("rst_if_done", 32'(if_done), 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      check("rst_mc_en", 32'(mc_en), 32'd0);
      check("rst_mc_pc", mc_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Cold miss, then warm hits in the same line
      miss_req(32'h0000_0104, 32'h0000_0100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1);
      hit_req(32'h0000_010C, 32'hA3);
      hit_req(32'h0000_0108, 32'hA2);
`ifdef ICACHE_STAT_EN
      check("stat_hit_after_seq", stat_hit, 32'd2);
      check("stat_miss_after_seq", stat_miss, 32'd1);
`endif

      // Conflict: same index, different tag evicts and forces a refetch
      miss_req(32'h0000_0500, 32'h0000_0500, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1);
      miss_req(32'h0000_0104, 32'h0000_0100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1);
      hit_req(32'h0000_0504 - 32'h0000_0400, 32'hC1);

      // Flush after the second word: fill completes, no response
      if_req = 1'b1;
      if_pc  = 32'h0000_0200;
      @(negedge clk);
      check("kill_no_done0", 32'(if_done), 32'd0);
      serve_fill(32'h0000_0200, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1, -1);
      @(negedge clk);
      check("kill_no_done1", 32'(if_done), 32'd0);
      @(negedge clk);
      check("kill_no_done2", 32'(if_done), 32'd0);
      check("kill_no_mc", 32'(mc_en), 32'd0);
      hit_req(32'h0000_0208, 32'hD2);

      // Flush in the same cycle as a request: not accepted
      if_req = 1'b1;
      if_pc  = 32'h0000_0204;
      flush  = 1'b1;
      @(negedge clk);
      flush  = 1'b0;
      if_req = 1'b0;
      check("flush_req_no_done", 32'(if_done), 32'd0);

      // rdy stall mid-fill while mc_done is held low
      miss_req(32'h0000_0300, 32'h0000_0300, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1);

      // Reset in the middle of a fill
      if_req = 1'b1;
      if_pc  = 32'h0000_040C;
      @(negedge clk);
      check("rstfill_mc_en", 32'(mc_en), 32'd1);
      check("rstfill_mc_pc", mc_pc, 32'h0000_0400);
      mc_done = 1'b1;
      mc_data = 32'h99;
      @(negedge clk);
      mc_done = 1'b0;
      @(negedge clk);
      check("rstfill_word1_req", 32'(mc_en), 32'd1);
      rst    = 1'b1;
      if_req = 1'b0;
      #1;
      check("rstfill_async_mc_en", 32'(mc_en), 32'd0);
      check("rstfill_async_mc_pc", mc_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
`ifdef ICACHE_STAT_EN
      check("stat_hit_rst", stat_hit, 32'd0);
      check("stat_miss_rst", stat_miss, 32'd0);
`endif
      @(negedge clk);
      check("post_rst_idle_mc", 32'(mc_en), 32'd0);
      // Previously hitting line must now miss
      miss_req(32'h0000_0208, 32'h0000_0200, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
